// File: rtl/viterbi_pkg.sv
// Shared code definitions for the rate-1/3 K=4 convolutional encoder and the Viterbi decoder.
// The decoder's branch-metric unit uses the same generators and soft levels, so encoder and decoder agree.
package viterbi_pkg;

  localparam int K          = 4;
  localparam int NUM_STATES = 8;

  // bit3 taps the current input bit, bit0 taps the input from three steps back
  localparam logic [K-1:0] CODE_G0 = 4'b1011;
  localparam logic [K-1:0] CODE_G1 = 4'b1101;
  localparam logic [K-1:0] CODE_G2 = 4'b1111;

  localparam int                SOFT_W    = 4;
  localparam logic [SOFT_W-1:0] SOFT_ZERO = 4'b0000;
  localparam logic [SOFT_W-1:0] SOFT_ONE  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

  function automatic logic tap_parity(input logic [K-1:0] gen, input logic [K-1:0] taps);
    return ^(gen & taps);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational tap/XOR network plus soft mapping: tap vector -> three soft symbols.
// Zero latency; no state and no flow control of its own.
module conv_enc_core #(
  parameter logic [viterbi_pkg::K-1:0]      G0        = viterbi_pkg::CODE_G0,
  parameter logic [viterbi_pkg::K-1:0]      G1        = viterbi_pkg::CODE_G1,
  parameter logic [viterbi_pkg::K-1:0]      G2        = viterbi_pkg::CODE_G2,
  parameter logic [viterbi_pkg::SOFT_W-1:0] SOFT_ZERO = viterbi_pkg::SOFT_ZERO,
  parameter logic [viterbi_pkg::SOFT_W-1:0] SOFT_ONE  = viterbi_pkg::SOFT_ONE
) (
  input  logic [viterbi_pkg::K-1:0]      taps,
  output logic [viterbi_pkg::SOFT_W-1:0] sym0,
  output logic [viterbi_pkg::SOFT_W-1:0] sym1,
  output logic [viterbi_pkg::SOFT_W-1:0] sym2
);
  import viterbi_pkg::*;

  logic [2:0] coded;

  assign coded[0] = tap_parity(G0, taps);
  assign coded[1] = tap_parity(G1, taps);
  assign coded[2] = tap_parity(G2, taps);

  assign sym0 = coded[0] ? SOFT_ONE : SOFT_ZERO;
  assign sym1 = coded[1] ? SOFT_ONE : SOFT_ZERO;
  assign sym2 = coded[2] ? SOFT_ONE : SOFT_ZERO;

endmodule

// File: rtl/conv_encoder_soft.sv
// Rate-1/3 K=4 zero-tail convolutional encoder with soft-level outputs; accepted bit -> triple 1 cycle later.
// A triple is loaded only when the output register is empty or being consumed; it is held under backpressure.
module conv_encoder_soft #(
  parameter int                             FRAME_LEN = 128,
  parameter logic [viterbi_pkg::K-1:0]      G0        = viterbi_pkg::CODE_G0,
  parameter logic [viterbi_pkg::K-1:0]      G1        = viterbi_pkg::CODE_G1,
  parameter logic [viterbi_pkg::K-1:0]      G2        = viterbi_pkg::CODE_G2,
  parameter logic [viterbi_pkg::SOFT_W-1:0] SOFT_ZERO = viterbi_pkg::SOFT_ZERO,
  parameter logic [viterbi_pkg::SOFT_W-1:0] SOFT_ONE  = viterbi_pkg::SOFT_ONE
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_bit,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [viterbi_pkg::SOFT_W-1:0]   yn_out0,
  output logic [viterbi_pkg::SOFT_W-1:0]   yn_out1,
  output logic [viterbi_pkg::SOFT_W-1:0]   yn_out2,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_sof,
  output logic                             out_eof,
  output logic                             busy
);
  import viterbi_pkg::*;

  localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  if (FRAME_LEN < 2 || FRAME_LEN > 4095) begin : g_bad_frame_len
    $error("conv_encoder_soft: FRAME_LEN must be in 2..4095");
  end

  enc_state_t          state;
  logic [2:0]          sreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [1:0]          tail_cnt;
  logic                free;
  logic                accept;
  logic                emit;
  logic                u_n;
  logic [K-1:0]        taps;
  logic [SOFT_W-1:0]   sym0;
  logic [SOFT_W-1:0]   sym1;
  logic [SOFT_W-1:0]   sym2;

  assign free     = !out_valid || out_ready;
  assign in_ready = ((state == IDLE) || (state == DATA)) && free;
  assign accept   = in_valid && in_ready;
  assign emit     = accept || ((state == TAIL) && free);
  assign busy     = (state != IDLE);

  // Tail triples push zeros through the register to return the code to state 0
  assign u_n  = (state == TAIL) ? 1'b0 : in_bit;
  assign taps = {u_n, sreg[0], sreg[1], sreg[2]};

  conv_enc_core #(
    .G0        (G0),
    .G1        (G1),
    .G2        (G2),
    .SOFT_ZERO (SOFT_ZERO),
    .SOFT_ONE  (SOFT_ONE)
  ) u_core (
    .taps (taps),
    .sym0 (sym0),
    .sym1 (sym1),
    .sym2 (sym2)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      tail_cnt  <= '0;
      out_valid <= 1'b0;
      yn_out0   <= SOFT_ZERO;
      yn_out1   <= SOFT_ZERO;
      yn_out2   <= SOFT_ZERO;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (emit) begin
        out_valid <= 1'b1;
        yn_out0   <= sym0;
        yn_out1   <= sym1;
        yn_out2   <= sym2;
        out_sof   <= (state == IDLE);
        out_eof   <= (state == TAIL) && (tail_cnt == 2'd2);
        sreg      <= {sreg[1:0], u_n};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            bit_cnt <= CNT_W'(1);
            state   <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_IDX) begin
              state    <= TAIL;
              tail_cnt <= '0;
            end
          end
        end
        TAIL: begin
          if (free) begin
            if (tail_cnt == 2'd2) begin
              state    <= IDLE;
              tail_cnt <= '0;
              bit_cnt  <= '0;
              sreg     <= '0;
            end else begin
              tail_cnt <= tail_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_soft.sv
// Randomised scoreboard bench for conv_encoder_soft against a history-based convolutional code model.
module tb_conv_encoder_soft;

  localparam int FRAME_LEN = 128;
  localparam int NTRIP     = FRAME_LEN + 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] yn_out0;
  logic [3:0] yn_out1;
  logic [3:0] yn_out2;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eof;
  logic       busy;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [3:0] y0;
    logic [3:0] y1;
    logic [3:0] y2;
  } trip_t;

  int    checks   = 0;
  int    failures = 0;
  trip_t exp_q[$];
  trip_t obs_q[$];
  bit    frame_bits[FRAME_LEN];
  int    hold_cnt    = 0;
  bit    rand_rdy    = 0;
  int    lowrdy_cnt  = 0;
  int    stall_cnt   = 0;
  bit    was_stalled = 0;
  trip_t held;
  trip_t cur;

  always #5 clk = ~clk;

  conv_encoder_soft #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .yn_out0   (yn_out0),
    .yn_out1   (yn_out1),
    .yn_out2   (yn_out2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Information bit u_j of the current frame; zero outside the frame (zero state before, zero tail after)
  function automatic bit u_at(input int j);
    if (j < 0 || j >= FRAME_LEN) return 1'b0;
    return frame_bits[j];
  endfunction

  // Triple n of a frame: coded bit k is the parity of the inputs u_{n-j} selected by generator bit (3-j)
  function automatic trip_t model_triple(input int n);
    logic [3:0] g[3];
    logic [3:0] s[3];
    bit         c;
    trip_t      r;
    g[0] = 4'b1011;
    g[1] = 4'b1101;
    g[2] = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      c = 1'b0;
      for (int j = 0; j < 4; j++)
        if (g[k][3-j]) c = c ^ u_at(n - j);
      s[k] = c ? 4'hF : 4'h0;
    end
    r.sof = (n == 0);
    r.eof = (n == NTRIP - 1);
    r.y0  = s[0];
    r.y1  = s[1];
    r.y2  = s[2];
    return r;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: a handshake seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    if (!reset_n) begin
      was_stalled = 0;
    end else begin
      cur = {out_sof, out_eof, yn_out0, yn_out1, yn_out2};
      if (busy && !in_ready) lowrdy_cnt++;
      if (was_stalled) begin
        check("hold_triple", cur, held);
        check("hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) begin
        stall_cnt++;
        check("in_ready_stall", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        obs_q.push_back(cur);
        if (exp_q.size() == 0) check("unexpected_triple", exp_q.size(), 1);
        else check("triple", cur, exp_q.pop_front());
      end
      was_stalled = out_valid && !out_ready;
      held = cur;
    end
  end

  // kind: 0 random, 1 all zero, 2 impulse, 3 random with first bit 1
  task automatic send_frame(input int kind, input int unsigned gap_pct, input int stall_at);
    int n = 0;
    int budget = 0;
    bit stalled = 0;
    while (n < FRAME_LEN) begin
      @(posedge clk);
      #1;
      if (n == stall_at && !stalled) begin
        hold_cnt = 5;
        stalled  = 1;
      end
      in_valid = ($urandom_range(99) >= gap_pct);
      case (kind)
        0:       in_bit = 1'($urandom_range(1));
        1:       in_bit = 1'b0;
        2:       in_bit = (n == 0);
        default: in_bit = (n == 0) ? 1'b1 : 1'($urandom_range(1));
      endcase
      @(negedge clk);
      if (in_valid && in_ready) begin
        frame_bits[n] = in_bit;
        exp_q.push_back(model_triple(n));
        if (n == FRAME_LEN - 1)
          for (int t = FRAME_LEN; t < NTRIP; t++) exp_q.push_back(model_triple(t));
        n++;
        budget = 0;
      end else begin
        budget++;
        if (budget > 200) begin
          check("accept_timeout", n, FRAME_LEN);
          break;
        end
      end
    end
  endtask

  task automatic end_input();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    trip_t e;
    int    nz;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_yn", {yn_out0, yn_out1, yn_out2}, 12'h000);
    check("rst_sof_eof", {out_sof, out_eof}, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Impulse response
    obs_q.delete();
    send_frame(2, 0, -1);
    end_input();
    drain();
    check("imp_count", obs_q.size(), NTRIP);
    if (obs_q.size() == NTRIP) begin
      e = {1'b1, 1'b0, 4'hF, 4'hF, 4'hF}; check("imp_t0", obs_q[0], e);
      e = {1'b0, 1'b0, 4'h0, 4'hF, 4'hF}; check("imp_t1", obs_q[1], e);
      e = {1'b0, 1'b0, 4'hF, 4'h0, 4'hF}; check("imp_t2", obs_q[2], e);
      e = {1'b0, 1'b0, 4'hF, 4'hF, 4'hF}; check("imp_t3", obs_q[3], e);
      e = {1'b0, 1'b0, 4'h0, 4'h0, 4'h0}; check("imp_t4", obs_q[4], e);
      e = {1'b0, 1'b1, 4'h0, 4'h0, 4'h0}; check("imp_last", obs_q[NTRIP-1], e);
    end

    // All-zero frame: in_ready low only during the three tail cycles
    obs_q.delete();
    lowrdy_cnt = 0;
    send_frame(1, 0, -1);
    end_input();
    drain();
    check("zero_tail_rdy_low", lowrdy_cnt, 3);
    check("zero_count", obs_q.size(), NTRIP);
    nz = 0;
    foreach (obs_q[i]) if ({obs_q[i].y0, obs_q[i].y1, obs_q[i].y2} != 12'h000) nz++;
    check("zero_symbols", nz, 0);
    if (obs_q.size() == NTRIP) begin
      check("zero_sof", {obs_q[0].sof, obs_q[1].sof}, 2'b10);
      check("zero_eof", {obs_q[NTRIP-2].eof, obs_q[NTRIP-1].eof}, 2'b01);
    end

    // Five-cycle backpressure in mid-frame
    stall_cnt = 0;
    send_frame(0, 0, 40);
    end_input();
    drain();
    check("stall_seen", stall_cnt >= 5, 1);

    // Reset after the first tail triple has been loaded
    send_frame(0, 0, -1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_tail_valid", out_valid, 0);
    check("rst_tail_busy", busy, 0);
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    obs_q.delete();
    reset_n = 1'b1;
    send_frame(3, 10, -1);
    end_input();
    drain();
    if (obs_q.size() > 0) begin
      e = {1'b1, 1'b0, 4'hF, 4'hF, 4'hF};
      check("post_rst_first", obs_q[0], e);
    end else begin
      check("post_rst_count", obs_q.size(), NTRIP);
    end

    // Random back-to-back frames with input gaps and random output backpressure
    rand_rdy = 1;
    for (int f = 0; f < 4; f++) send_frame(0, 30, -1);
    end_input();
    drain();
    rand_rdy = 0;
    repeat (5) @(negedge clk);
    check("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
